// File: rtl/codificador_rgb.sv
// codificador_rgb: debounces a 3-bit RGB colour code and emits one one-hot game code per press.
module codificador_rgb #(
    parameter int ESTAVEL_CICLOS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic [2:0] rgb_in,
    output logic [3:0] dados,
    output logic       pronto,
    output logic       erro,
    output logic       ocupado,
    output logic [1:0] db_estado
);
    localparam int CW = $clog2(ESTAVEL_CICLOS) + 1;
    localparam logic [CW-1:0] CONT_MAX = CW'(ESTAVEL_CICLOS - 1);

    typedef enum logic [1:0] {OCIOSO, ESTABILIZA, EMITE, SOLTA} estado_t;

    estado_t       estado_q, estado_d;
    logic [CW-1:0] cont_q, cont_d;
    logic [2:0]    amostra_q, amostra_d;
    logic [3:0]    dados_q, dados_d;
    logic          pronto_q, pronto_d;
    logic          erro_q, erro_d;
    logic [3:0]    onehot;

    // 000 never reaches here as a sample, so zero marks the invalid codes 101/110/111
    always_comb
        onehot = amostra_q == 3'b010 ? 4'b0001 :
                 amostra_q == 3'b100 ? 4'b0010 :
                 amostra_q == 3'b011 ? 4'b0100 :
                 amostra_q == 3'b001 ? 4'b1000 : 4'b0000;

    always_comb begin
        estado_d  = estado_q;
        cont_d    = cont_q;
        amostra_d = amostra_q;
        dados_d   = dados_q;
        pronto_d  = 1'b0;
        erro_d    = 1'b0;
        if (!en) begin
            estado_d = OCIOSO;
            cont_d   = '0;
            dados_d  = '0;
        end else begin
            case (estado_q)
                OCIOSO: if (rgb_in != 3'b000) begin
                    amostra_d = rgb_in;
                    cont_d    = '0;
                    estado_d  = ESTABILIZA;
                end
                ESTABILIZA: if (rgb_in != amostra_q) begin
                    estado_d = OCIOSO;
                    cont_d   = '0;
                end else if (cont_q < CONT_MAX) begin
                    cont_d = cont_q + 1'b1;
                end else begin
                    estado_d = EMITE;
                    dados_d  = onehot != 4'b0000 ? onehot : dados_q;
                    pronto_d = onehot != 4'b0000;
                    erro_d   = onehot == 4'b0000;
                end
                EMITE: estado_d = SOLTA;
                SOLTA: estado_d = rgb_in == 3'b000 ? OCIOSO : SOLTA;
                default: estado_d = OCIOSO;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= OCIOSO;
            cont_q    <= '0;
            amostra_q <= '0;
            dados_q   <= '0;
            pronto_q  <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            cont_q    <= cont_d;
            amostra_q <= amostra_d;
            dados_q   <= dados_d;
            pronto_q  <= pronto_d;
            erro_q    <= erro_d;
        end
    end

    assign dados     = dados_q;
    assign pronto    = pronto_q;
    assign erro      = erro_q;
    assign ocupado   = estado_q != OCIOSO;
    assign db_estado = estado_q;
endmodule
